// File: rtl/io_bus_pkg.sv
// Shared types and helpers for the IO bus router: FSM states, error data default,
// and compile-time utilities for unpacking the per-slave address windows.
package io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_BUSY = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    // Upper bounds for the window-slicing helper; ADDR_W above 64 is not supported.
    localparam int MAX_SLAVES = 16;
    localparam int MAX_ADDR_W = 64;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] param_slice(
        input logic [MAX_SLAVES*MAX_ADDR_W-1:0] vec,
        input int                               idx,
        input int                               width
    );
        logic [MAX_ADDR_W-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_ADDR_W; b++) begin
            if (b < width) r[b] = vec[idx*width + b];
        end
        return r;
    endfunction

endpackage

// File: rtl/io_addr_decoder.sv
// Combinational address window match; on overlapping windows the lowest slave index wins.
module io_addr_decoder
    import io_bus_pkg::*;
#(
    parameter int                         N_SLAVES   = 4,
    parameter int                         ADDR_W     = 32,
    parameter int                         IDX_W      = 2,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = {N_SLAVES{32'hF000_0000}}
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  index
);

    localparam logic [MAX_SLAVES*MAX_ADDR_W-1:0] BASE_X = (MAX_SLAVES*MAX_ADDR_W)'(SLAVE_BASE);
    localparam logic [MAX_SLAVES*MAX_ADDR_W-1:0] MASK_X = (MAX_SLAVES*MAX_ADDR_W)'(SLAVE_MASK);

    logic [N_SLAVES-1:0] match;

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_win
        localparam logic [ADDR_W-1:0] BASE_I = ADDR_W'(param_slice(BASE_X, i, ADDR_W));
        localparam logic [ADDR_W-1:0] MASK_I = ADDR_W'(param_slice(MASK_X, i, ADDR_W));
        assign match[i] = ((addr & MASK_I) == (BASE_I & MASK_I));
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/io_bus_router.sv
// Routes one strobe/ready master IO bus to N_SLAVES peripheral ports by address window,
// with registered forwarding, per-transaction timeout, decode-miss error and protocol flag.
module io_bus_router
    import io_bus_pkg::*;
#(
    parameter int                         N_SLAVES       = 4,
    parameter int                         ADDR_W         = 32,
    parameter int                         DATA_W         = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE     = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK     = {N_SLAVES{32'hF000_0000}},
    parameter int                         TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                ERR_DATA       = ERR_DATA_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         m_addr_strobe,
    input  logic                         m_read_strobe,
    input  logic                         m_write_strobe,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W/8-1:0]          m_byte_enable,
    input  logic [DATA_W-1:0]            m_write_data,
    output logic [DATA_W-1:0]            m_read_data,
    output logic                         m_ready,
    output logic                         m_error,
    output logic [N_SLAVES-1:0]          s_addr_strobe,
    output logic [N_SLAVES-1:0]          s_read_strobe,
    output logic [N_SLAVES-1:0]          s_write_strobe,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W/8-1:0]          s_byte_enable,
    output logic [DATA_W-1:0]            s_write_data,
    input  logic [N_SLAVES*DATA_W-1:0]   s_read_data,
    input  logic [N_SLAVES-1:0]          s_ready,
    output logic                         proto_violation
);

    localparam int                BE_W  = DATA_W / 8;
    localparam int                IDX_W = (N_SLAVES > 1) ? clog2(N_SLAVES) : 1;
    localparam int                CNT_W = (clog2(TIMEOUT_CYCLES + 1) > 0) ? clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [DATA_W-1:0] ERR_D = DATA_W'(ERR_DATA);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [N_SLAVES-1:0] s_as_q, s_as_d;
    logic [N_SLAVES-1:0] s_rs_q, s_rs_d;
    logic [N_SLAVES-1:0] s_ws_q, s_ws_d;
    logic                m_ready_q, m_ready_d;
    logic                m_error_q, m_error_d;
    logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
    logic                proto_q, proto_d;

    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;
    logic                last_busy;

    io_addr_decoder #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .addr  (m_addr),
        .hit   (dec_hit),
        .index (dec_idx)
    );

    assign sel_ready = s_ready[sel_q];
    assign sel_rdata = s_read_data[int'(sel_q)*DATA_W +: DATA_W];
    // Terminal BUSY cycle: the counter is about to reach TIMEOUT_CYCLES-1.
    assign last_busy = (int'(cnt_q) + 1 >= TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        s_as_d    = '0;
        s_rs_d    = '0;
        s_ws_d    = '0;
        m_ready_d = 1'b0;
        m_error_d = 1'b0;
        m_rdata_d = '0;
        proto_d   = proto_q;

        if (m_addr_strobe && state_q != ST_IDLE) proto_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (m_addr_strobe) begin
                    addr_d  = m_addr;
                    be_d    = m_byte_enable;
                    wdata_d = m_write_data;
                    rd_d    = m_read_strobe;
                    // Ambiguous direction (both or neither qualifier) is answered like a miss.
                    if (dec_hit && (m_read_strobe ^ m_write_strobe)) begin
                        sel_d           = dec_idx;
                        s_as_d[dec_idx] = 1'b1;
                        s_rs_d[dec_idx] = m_read_strobe;
                        s_ws_d[dec_idx] = m_write_strobe;
                        state_d         = ST_FWD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_FWD: begin
                cnt_d = '0;
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_busy) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                m_ready_d = 1'b1;
                m_error_d = err_q;
                m_rdata_d = err_q ? ERR_D : (rd_q ? rdata_q : '0);
                err_d     = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            s_as_q    <= '0;
            s_rs_q    <= '0;
            s_ws_q    <= '0;
            m_ready_q <= 1'b0;
            m_error_q <= 1'b0;
            m_rdata_q <= '0;
            proto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            s_as_q    <= s_as_d;
            s_rs_q    <= s_rs_d;
            s_ws_q    <= s_ws_d;
            m_ready_q <= m_ready_d;
            m_error_q <= m_error_d;
            m_rdata_q <= m_rdata_d;
            proto_q   <= proto_d;
        end
    end

    assign m_ready         = m_ready_q;
    assign m_error         = m_error_q;
    assign m_read_data     = m_rdata_q;
    assign s_addr_strobe   = s_as_q;
    assign s_read_strobe   = s_rs_q;
    assign s_write_strobe  = s_ws_q;
    assign s_addr          = addr_q;
    assign s_byte_enable   = be_q;
    assign s_write_data    = wdata_q;
    assign proto_violation = proto_q;

endmodule

// File: tb/tb_io_bus_router.sv
// Self-checking bench for io_bus_router: directed scenarios then random transactions
// compared against a transaction-level latency/response model.
module tb_io_bus_router;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 8;
    // Slave 3 overlaps slave 2 over 0x2xxx_xxxx; slave 2 must win there.
    localparam logic [NS*AW-1:0] BASE = {32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASK = {32'hE000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              m_addr_strobe = 1'b0;
    logic              m_read_strobe = 1'b0;
    logic              m_write_strobe = 1'b0;
    logic [AW-1:0]     m_addr = '0;
    logic [BW-1:0]     m_byte_enable = '0;
    logic [DW-1:0]     m_write_data = '0;
    logic [DW-1:0]     m_read_data;
    logic              m_ready;
    logic              m_error;
    logic [NS-1:0]     s_addr_strobe;
    logic [NS-1:0]     s_read_strobe;
    logic [NS-1:0]     s_write_strobe;
    logic [AW-1:0]     s_addr;
    logic [BW-1:0]     s_byte_enable;
    logic [DW-1:0]     s_write_data;
    logic [NS*DW-1:0]  s_read_data = '0;
    logic [NS-1:0]     s_ready = '0;
    logic              proto_violation;

    always #5 clk = ~clk;

    io_bus_router #(
        .N_SLAVES       (NS),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .SLAVE_BASE     (BASE),
        .SLAVE_MASK     (MASK),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m_addr_strobe   (m_addr_strobe),
        .m_read_strobe   (m_read_strobe),
        .m_write_strobe  (m_write_strobe),
        .m_addr          (m_addr),
        .m_byte_enable   (m_byte_enable),
        .m_write_data    (m_write_data),
        .m_read_data     (m_read_data),
        .m_ready         (m_ready),
        .m_error         (m_error),
        .s_addr_strobe   (s_addr_strobe),
        .s_read_strobe   (s_read_strobe),
        .s_write_strobe  (s_write_strobe),
        .s_addr          (s_addr),
        .s_byte_enable   (s_byte_enable),
        .s_write_data    (s_write_data),
        .s_read_data     (s_read_data),
        .s_ready         (s_ready),
        .proto_violation (proto_violation)
    );

    int          checks = 0;
    int          errors = 0;
    bit          pv_model = 1'b0;
    logic [31:0] win_base [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h2000_0000};
    logic [31:0] win_mask [NS] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hE000_0000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_target(input logic [31:0] addr);
        for (int i = 0; i < NS; i++)
            if ((addr & win_mask[i]) == (win_base[i] & win_mask[i])) return i;
        return -1;
    endfunction

    // One master transaction. lat = cycles from the slave strobe to its ready pulse;
    // inject = cycle (after the master strobe) at which a stray master strobe is sent, 0 = none.
    task automatic run_txn(input logic [31:0] addr, input bit rd, input bit wr,
                           input logic [3:0] be, input logic [31:0] wd, input int lat,
                           input logic [31:0] rdat, input int inject, input bit noise);
        int            tgt, exp_k, seen_k, nready;
        bit            ok, exp_err;
        logic [31:0]   exp_data;
        logic [NS-1:0] exp_oh;
        tgt = ref_target(addr);
        ok  = (tgt >= 0) && (rd != wr);
        if (!ok) begin
            exp_k = 2; exp_err = 1'b1;
        end else if (lat <= TO - 1) begin
            exp_k = lat + 3; exp_err = 1'b0;
        end else begin
            exp_k = TO + 2; exp_err = 1'b1;
        end
        exp_data = exp_err ? 32'hDEAD_BEEF : (rd ? rdat : 32'h0);
        exp_oh   = ok ? (NS'(1) << tgt) : '0;
        if (inject >= 1 && inject < exp_k) pv_model = 1'b1;

        @(negedge clk);
        m_addr_strobe = 1'b1; m_read_strobe = rd; m_write_strobe = wr;
        m_addr = addr; m_byte_enable = be; m_write_data = wd; s_ready = '0;
        seen_k = -1; nready = 0;
        for (int k = 1; k <= exp_k + 3; k++) begin
            @(negedge clk);
            m_addr_strobe  = (k == inject);
            m_read_strobe  = (k == inject);
            m_write_strobe = 1'b0;
            if (k == 1) begin
                chk("s_addr_strobe", s_addr_strobe, exp_oh);
                chk("s_read_strobe", s_read_strobe, rd ? exp_oh : '0);
                chk("s_write_strobe", s_write_strobe, wr ? exp_oh : '0);
                chk("s_addr", s_addr, addr);
                chk("s_byte_enable", s_byte_enable, be);
                chk("s_write_data", s_write_data, wd);
            end
            if (k == 2) chk("s_addr_strobe_pulse", s_addr_strobe, 0);
            if (m_ready) begin
                nready++;
                if (seen_k < 0) begin
                    seen_k = k;
                    chk("m_error", m_error, exp_err);
                    chk("m_read_data", m_read_data, exp_data);
                end
            end
            s_read_data = {$urandom, $urandom, $urandom, $urandom};
            s_ready = noise ? (NS'($urandom) & ~exp_oh) : '0;
            if (ok && k == 1 + lat) begin
                s_ready[tgt] = 1'b1;
                s_read_data[tgt*DW +: DW] = rdat;
            end
        end
        s_ready = '0;
        chk("m_ready_latency", seen_k, exp_k);
        chk("m_ready_count", nready, 1);
        chk("proto_violation", proto_violation, pv_model);
    endtask

    initial begin
        int quiet;
        logic [31:0] ra;
        int r;

        repeat (3) @(negedge clk);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_m_error", m_error, 0);
        chk("rst_m_read_data", m_read_data, 0);
        chk("rst_s_addr_strobe", s_addr_strobe, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_proto", proto_violation, 0);
        rst_n = 1'b1;

        run_txn(32'h2000_0000, 1, 0, 4'hF, 32'h0, 4, 32'h1234_5678, 0, 0);  // slave 2 wins overlap
        run_txn(32'h1000_0010, 0, 1, 4'b0011, 32'hA5A5_0000, 0, 32'h0, 0, 0);
        run_txn(32'hF000_0000, 1, 0, 4'hF, 32'h0, 0, 32'h0, 0, 0);           // decode miss
        run_txn(32'h3000_0100, 1, 0, 4'hF, 32'h0, 10, 32'h7777_0001, 0, 0); // timeout, late ready
        run_txn(32'h0000_0040, 1, 0, 4'hF, 32'h0, TO - 1, 32'hCAFE_F00D, 0, 1); // terminal-count ready
        run_txn(32'h1000_0000, 1, 1, 4'hF, 32'h1, 1, 32'h0, 0, 0);          // both qualifiers
        run_txn(32'h1000_0000, 0, 0, 4'hF, 32'h1, 1, 32'h0, 0, 0);          // neither qualifier
        run_txn(32'h2000_0008, 1, 0, 4'hF, 32'h0, 3, 32'h0BAD_F00D, 3, 1);  // stray strobe in BUSY

        for (int n = 0; n < 40; n++) begin
            ra = {4'($urandom_range(0, 5)), 28'($urandom)};
            r  = $urandom_range(0, 9);
            run_txn(ra, (r == 0) || (r >= 2 && r % 2 == 0), (r == 0) || (r >= 2 && r % 2 == 1),
                    4'($urandom), $urandom, $urandom_range(0, 9), $urandom, 0, 1'($urandom));
        end

        // Reset in the middle of BUSY, then a late ready must not complete anything.
        @(negedge clk);
        m_addr_strobe = 1'b1; m_read_strobe = 1'b1; m_addr = 32'h2000_0004;
        @(negedge clk);
        m_addr_strobe = 1'b0; m_read_strobe = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_m_ready", m_ready, 0);
        chk("midrst_s_addr", s_addr, 0);
        chk("midrst_proto", proto_violation, 0);
        rst_n = 1'b1;
        pv_model = 1'b0;
        s_ready = 4'b0100;
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (m_ready) quiet++;
        end
        s_ready = '0;
        chk("midrst_no_ready", quiet, 0);

        run_txn(32'h1000_0020, 1, 0, 4'hF, 32'h0, 2, 32'h5555_AAAA, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
